// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding, default sizes and width helpers for the SNN layer engine
package snn_pkg;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;
  localparam int N_IN_DEF = 784;
  localparam int N_OUT_DEF = 10;
  localparam int W_BITS_DEF = 8;
  localparam int OUT_BITS_DEF = 8;
  function automatic int aw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int acc_w(int w_bits, int n_in);
    return w_bits + aw(n_in) + 1;
  endfunction
endpackage

// File: rtl/snn_layer_engine_if.sv
// snn_layer_engine_if: host control, spike/weight memory read ports and result write port
interface snn_layer_engine_if import snn_pkg::*; #(
  parameter int N_IN = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int W_BITS = W_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
);
  logic start;
  logic relu_en;
  logic [aw(N_IN)-1:0] in_addr;
  logic in_q;
  logic [aw(N_IN*N_OUT)-1:0] wt_addr;
  logic signed [W_BITS-1:0] wt_q;
  logic out_we;
  logic [aw(N_OUT)-1:0] out_addr;
  logic signed [OUT_BITS-1:0] out_data;
  logic busy;
  logic done;
  logic [aw(N_OUT)-1:0] class_idx;
  modport master (output start, relu_en, in_q, wt_q,
                  input in_addr, wt_addr, out_we, out_addr, out_data, busy, done, class_idx);
  modport slave (input start, relu_en, in_q, wt_q,
                 output in_addr, wt_addr, out_we, out_addr, out_data, busy, done, class_idx);
endinterface

// File: rtl/snn_argmax.sv
// snn_argmax: running maximum; init loads unconditionally, upd loads only on a strictly greater value
module snn_argmax #(
  parameter int VAL_BITS = 8,
  parameter int IDX_BITS = 4
) (
  input logic clk,
  input logic rst,
  input logic init,
  input logic upd,
  input logic signed [VAL_BITS-1:0] val,
  input logic [IDX_BITS-1:0] idx,
  output logic [IDX_BITS-1:0] max_idx
);
  logic signed [VAL_BITS-1:0] max_val;
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (init || (upd && val > max_val)) begin
      max_val <= val;
      max_idx <= idx;
    end
  end
endmodule

// File: rtl/snn_layer_engine.sv
// snn_layer_engine: fully connected spiking layer; per neuron a serial weight MAC over the
// input spikes, saturating/ReLU output write, and argmax over the layer.
module snn_layer_engine import snn_pkg::*; #(
  parameter int N_IN = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int W_BITS = W_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input logic clk,
  input logic rst,
  snn_layer_engine_if.slave bus
);
  localparam int IA = aw(N_IN);
  localparam int WA = aw(N_IN*N_OUT);
  localparam int OA = aw(N_OUT);
  localparam int AW = acc_w(W_BITS, N_IN);
  localparam logic signed [AW-1:0] SMAX = AW'((1 <<< (OUT_BITS-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);
  state_t st;
  logic [IA-1:0] i;
  logic [WA-1:0] wa;
  logic [OA-1:0] o;
  logic signed [AW-1:0] acc, acc_nx, sat_v;
  logic signed [OUT_BITS-1:0] res;
  logic vld, relu;
  logic [OA-1:0] am_idx;
  // vld marks a cycle whose memory data belongs to an address issued in the previous cycle
  always_comb begin
    acc_nx = acc + ((vld && bus.in_q) ? AW'(bus.wt_q) : '0);
    sat_v = acc_nx > SMAX ? SMAX : (acc_nx < SMIN ? SMIN : acc_nx);
    res = (relu && sat_v < 0) ? '0 : OUT_BITS'(sat_v);
  end
  assign bus.in_addr = i;
  assign bus.wt_addr = wa;
  snn_argmax #(.VAL_BITS(OUT_BITS), .IDX_BITS(OA)) u_argmax (
    .clk(clk),
    .rst(rst),
    .init(st == DRAIN && o == '0),
    .upd(st == DRAIN && o != '0),
    .val(res),
    .idx(o),
    .max_idx(am_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      i <= '0;
      wa <= '0;
      o <= '0;
      acc <= '0;
      vld <= 1'b0;
      relu <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out_we <= 1'b0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
      bus.class_idx <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.out_we <= 1'b0;
      vld <= 1'b0;
      case (st)
        IDLE: if (bus.start) begin
          st <= MAC;
          i <= '0;
          wa <= '0;
          o <= '0;
          acc <= '0;
          relu <= bus.relu_en;
          bus.busy <= 1'b1;
        end
        MAC: begin
          vld <= 1'b1;
          acc <= acc_nx;
          wa <= wa + WA'(1);
          i <= i == IA'(N_IN-1) ? '0 : i + IA'(1);
          st <= i == IA'(N_IN-1) ? DRAIN : MAC;
        end
        DRAIN: begin
          acc <= acc_nx;
          bus.out_we <= 1'b1;
          bus.out_addr <= o;
          bus.out_data <= res;
          st <= WRITE;
        end
        WRITE: if (o == OA'(N_OUT-1)) begin
          st <= DONE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.class_idx <= am_idx;
        end else begin
          st <= MAC;
          o <= o + OA'(1);
          acc <= '0;
        end
        default: begin
          st <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
